// File: rtl/pp_pipeline_accel_fifo_wm.sv
// Parametrised shift-register FWFT stream FIFO with watermark and sticky error flags.
// Optional registered output stage enabled by defining PP_FIFO_OUT_REG_EN.
module pp_pipeline_accel_fifo_wm #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int ADDR_WIDTH    = 2,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  if_almost_empty,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nx;
  logic [CW-1:0]         occ_nx;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [DATA_WIDTH-1:0] head;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  st_pop;
  logic                  full_n_r;
  logic                  af_r;
  logic                  ae_r;
  logic                  ovf_r;
  logic                  unf_r;

  assign wr_acc   = if_write & if_write_ce & full_n_r;
  // Oldest word sits at entry cnt-1 because every write shifts storage up.
  assign head_idx = (cnt == '0) ? '0 : ADDR_WIDTH'(cnt - CW'(1));
  assign head     = mem[head_idx];

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= if_din;
    end
  end

  always_comb begin
    cnt_nx = cnt;
    case ({wr_acc, st_pop})
      2'b10:   cnt_nx = cnt + CW'(1);
      2'b01:   cnt_nx = cnt - CW'(1);
      default: cnt_nx = cnt;
    endcase
  end

`ifdef PP_FIFO_OUT_REG_EN
  logic                  out_valid;
  logic                  ov_nx;
  logic [DATA_WIDTH-1:0] out_data;

  assign rd_acc = if_read & if_read_ce & out_valid;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign st_pop = (cnt != '0) & (~out_valid | rd_acc);

  always_comb begin
    ov_nx = out_valid;
    if (st_pop) begin
      ov_nx = 1'b1;
    end else if (rd_acc) begin
      ov_nx = 1'b0;
    end
  end

  assign occ_nx = cnt_nx + CW'(ov_nx);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= ov_nx;
      if (st_pop) begin
        out_data <= head;
      end
    end
  end

  assign if_dout           = out_data;
  assign if_empty_n        = out_valid;
  assign if_num_data_valid = cnt + CW'(out_valid);
  assign if_fifo_cap       = CW'(DEPTH + 1);
`else
  logic empty_n_r;

  assign rd_acc = if_read & if_read_ce & empty_n_r;
  assign st_pop = rd_acc;
  assign occ_nx = cnt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      empty_n_r <= 1'b0;
    end else begin
      empty_n_r <= (cnt_nx != '0);
    end
  end

  assign if_dout           = head;
  assign if_empty_n        = empty_n_r;
  assign if_num_data_valid = cnt;
  assign if_fifo_cap       = DEPTH_C;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      full_n_r <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      full_n_r <= (cnt_nx != DEPTH_C);
      af_r     <= (cnt_nx >= AF_C);
      ae_r     <= (occ_nx <= AE_C);
      if (if_write && if_write_ce && !full_n_r) begin
        ovf_r <= 1'b1;
      end
      if (if_read && if_read_ce && !if_empty_n) begin
        unf_r <= 1'b1;
      end
    end
  end

  assign if_full_n       = full_n_r;
  assign if_almost_full  = af_r;
  assign if_almost_empty = ae_r;
  assign if_overflow     = ovf_r;
  assign if_underflow    = unf_r;

endmodule
